// File: rtl/npu_pkg.sv
// Shared NPU definitions: default array geometry, lane slicing
// and FIFO level width helper used by the skew/deskew blocks.
package npu_pkg;

  localparam int NPU_N     = 8;
  localparam int NPU_ACC_W = 32;

  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [NPU_ACC_W-1:0] lane(
    input logic [NPU_N*NPU_ACC_W-1:0] v,
    input int                         j
  );
    return v[j*NPU_ACC_W +: NPU_ACC_W];
  endfunction

endpackage

// File: rtl/systolic_output_deskew_if.sv
// Valid/ready bus carrying row-aligned result vectors
// from the deskew collector toward writeback.
interface systolic_output_deskew_if
  import npu_pkg::*;
#(
  parameter int N         = NPU_N,
  parameter int ACC_WIDTH = NPU_ACC_W
);

  logic                   m_valid;
  logic                   m_ready;
  logic [N*ACC_WIDTH-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/npu_sync_fifo.sv
// Synchronous FIFO with registered head output, level count
// and drop indication when a push meets a full, non-popping FIFO.
module npu_sync_fifo
  import npu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [fifo_lvl_w(DEPTH)-1:0] level,
  output logic                         drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = fifo_lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_nx;
  logic [LW-1:0]    count;
  logic [LW-1:0]    count_nx;
  logic [LW-1:0]    kept;
  logic [WIDTH-1:0] head_nx;
  logic             pop;
  logic             full;
  logic             push_ok;

  assign pop      = out_valid & out_ready;
  assign full     = (count == LW'(DEPTH));
  assign push_ok  = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign rd_nx    = rd_ptr + AW'(pop);
  assign kept     = count - LW'(pop);
  assign count_nx = kept + LW'(push_ok);
  assign level    = count;

  // Next head: oldest surviving entry, else bypass the new push.
  always_comb begin
    head_nx = '0;
    if (kept != '0)
      head_nx = mem[rd_nx];
    else if (push_ok)
      head_nx = push_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push_ok);
      rd_ptr    <= rd_nx;
      count     <= count_nx;
      out_valid <= (count_nx != '0);
      out_data  <= head_nx;
    end
  end

endmodule

// File: rtl/systolic_output_deskew.sv
// Deskews systolic array column outputs into aligned vectors and
// queues them. Build option DESKEW_RELU_EN zeroes negative lanes.
module systolic_output_deskew
  import npu_pkg::*;
#(
  parameter int N          = NPU_N,
  parameter int ACC_WIDTH  = NPU_ACC_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic [N*ACC_WIDTH-1:0]            y_in,
  input  logic [N-1:0]                      y_valid,
  systolic_output_deskew_if.master          m,
  output logic [fifo_lvl_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic                              overflow,
  output logic                              misalign_err
);

  localparam int            GW     = $clog2(N) + 1;
  localparam logic [GW-1:0] G_INIT = GW'(N - 1);

  logic [N-1:0]           av;
  logic [N*ACC_WIDTH-1:0] ad;
  logic [N*ACC_WIDTH-1:0] pd;
  logic [GW-1:0]          guard;
  logic                   armed;
  logic                   push;
  logic                   mis_hit;
  logic                   drop;

  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_direct
      assign av[j] = y_valid[j];
      assign ad[j*ACC_WIDTH +: ACC_WIDTH] =
        y_in[j*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic                 v_q [D];
      logic [ACC_WIDTH-1:0] d_q [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) begin
            v_q[k] <= 1'b0;
            d_q[k] <= '0;
          end
        end else if (clear) begin
          for (int k = 0; k < D; k++) begin
            v_q[k] <= 1'b0;
            d_q[k] <= '0;
          end
        end else begin
          v_q[0] <= y_valid[j];
          d_q[0] <= y_in[j*ACC_WIDTH +: ACC_WIDTH];
          for (int k = 1; k < D; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end
      assign av[j] = v_q[D-1];
      assign ad[j*ACC_WIDTH +: ACC_WIDTH] = d_q[D-1];
    end
  end

  always_comb begin
    pd = ad;
`ifdef DESKEW_RELU_EN
    for (int j = 0; j < N; j++) begin
      if (ad[j*ACC_WIDTH + ACC_WIDTH - 1])
        pd[j*ACC_WIDTH +: ACC_WIDTH] = '0;
    end
`endif
  end

  // Vectors in flight at reset/clear land within N-1 edges; ignore them.
  assign armed   = (guard == '0);
  assign push    = armed & (&av);
  assign mis_hit = armed & (av != '0) & ~(&av);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard        <= G_INIT;
      overflow     <= 1'b0;
      misalign_err <= 1'b0;
    end else if (clear) begin
      guard        <= G_INIT;
      overflow     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (!armed)
        guard <= guard - 1'b1;
      if (mis_hit)
        misalign_err <= 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

  npu_sync_fifo #(
    .WIDTH (N*ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (pd),
    .out_valid (m.m_valid),
    .out_ready (m.m_ready),
    .out_data  (m.m_data),
    .level     (fifo_level),
    .drop      (drop)
  );

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Scoreboard bench for systolic_output_deskew: skewed directed
// vectors in, aligned vectors checked against a queue on pop.
module tb_systolic_output_deskew;
  import npu_pkg::*;

  localparam int N     = 8;
  localparam int W     = 32;
  localparam int DW    = N * W;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [DW-1:0] y_in;
  logic [N-1:0]  y_valid;
  logic [2:0]    lvl;
  logic          ovf;
  logic          mis;

  systolic_output_deskew_if #(.N(N), .ACC_WIDTH(W)) m_if ();

  systolic_output_deskew #(
    .N          (N),
    .ACC_WIDTH  (W),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .y_in         (y_in),
    .y_valid      (y_valid),
    .m            (m_if),
    .fifo_level   (lvl),
    .overflow     (ovf),
    .misalign_err (mis)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  int            maxlvl = 0;
  logic [DW-1:0] expq [$];
  logic [DW-1:0] vbuf [8];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Monitor: every accepted output vector is compared with the queue head.
  always @(negedge clk) begin
    if (rst_n && m_if.m_valid && m_if.m_ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected act=%h", m_if.m_data);
      end else begin
        chk("pop_data", m_if.m_data, expq.pop_front());
      end
    end
    if (int'(lvl) > maxlvl) maxlvl = int'(lvl);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mkvec(input int b);
    logic [DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*W +: W] = W'(b + j);
    return v;
  endfunction

  // Drive skew cycles c_lo..c_hi of vectors vbuf[base..base+cnt-1].
  task automatic drive(input int base, input int cnt, input int badc,
                       input int c_lo, input int c_hi, input bit rdy_last);
    for (int c = c_lo; c <= c_hi; c++) begin
      y_valid = '0;
      y_in    = '0;
      for (int j = 0; j < N; j++) begin
        int k = c - j;
        if (k >= 0 && k < cnt && !(k == 0 && j == badc)) begin
          y_valid[j]     = 1'b1;
          y_in[j*W +: W] = vbuf[base+k][j*W +: W];
        end
      end
      if (rdy_last && c == c_hi) m_if.m_ready = 1'b1;
      tick();
    end
    y_valid = '0;
    y_in    = '0;
    if (rdy_last) m_if.m_ready = 1'b0;
  endtask

  task automatic send(input int base, input int cnt, input int badc,
                      input bit rdy_last);
    drive(base, cnt, badc, 0, cnt + N - 2, rdy_last);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    m_if.m_ready = 1'b1;
    while (expq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    chkn("drain_done", expq.size(), 0);
    m_if.m_ready = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chkn({nm, "_valid"}, int'(m_if.m_valid), 0);
    chk({nm, "_data"}, m_if.m_data, '0);
    chkn({nm, "_level"}, int'(lvl), 0);
    chkn({nm, "_ovf"}, int'(ovf), 0);
    chkn({nm, "_mis"}, int'(mis), 0);
  endtask

  initial begin
    logic [DW-1:0] rv;
    logic [DW-1:0] re;
    rst_n        = 1'b0;
    clear        = 1'b0;
    y_in         = '0;
    y_valid      = '0;
    m_if.m_ready = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (N + 1) tick();

    // Single vector, latency one cycle after column N-1.
    vbuf[0] = mkvec(100);
    m_if.m_ready = 1'b1;
    expq.push_back(vbuf[0]);
    drive(0, 1, -1, 0, N - 2, 1'b0);
    chkn("single_pre_valid", int'(m_if.m_valid), 0);
    drive(0, 1, -1, N - 1, N - 1, 1'b0);
    chkn("single_valid", int'(m_if.m_valid), 1);
    chk("single_data", m_if.m_data, vbuf[0]);
    repeat (2) tick();
    chkn("single_level", int'(lvl), 0);
    chkn("single_q", expq.size(), 0);

    // Back-to-back vectors with the consumer always ready.
    for (int i = 0; i < 4; i++) begin
      vbuf[i] = mkvec(1000 * (i + 1));
      expq.push_back(vbuf[i]);
    end
    maxlvl = 0;
    send(0, 4, -1, 1'b0);
    tick();
    chkn("b2b_level", int'(lvl), 0);
    chkn("b2b_q", expq.size(), 0);
    chkn("b2b_maxlvl", maxlvl, 1);

    // Overflow: five vectors into a depth-4 FIFO with no consumer.
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) vbuf[i] = mkvec(2000 + 16 * i);
    for (int i = 0; i < 4; i++) expq.push_back(vbuf[i]);
    send(0, 5, -1, 1'b0);
    chkn("ovf_level", int'(lvl), 4);
    chkn("ovf_flag", int'(ovf), 1);
    chk("ovf_head", m_if.m_data, vbuf[0]);
    repeat (2) tick();
    chk("ovf_hold", m_if.m_data, vbuf[0]);
    drain(20);
    chkn("ovf_drained", int'(lvl), 0);
    chkn("ovf_sticky", int'(ovf), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chkn("ovf_cleared", int'(ovf), 0);
    repeat (N) tick();

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 5; i++) vbuf[i] = mkvec(3000 + 16 * i);
    for (int i = 0; i < 4; i++) expq.push_back(vbuf[i]);
    send(0, 4, -1, 1'b0);
    chkn("pp_full", int'(lvl), 4);
    expq.push_back(vbuf[4]);
    send(4, 1, -1, 1'b1);
    chkn("pp_level", int'(lvl), 4);
    chkn("pp_ovf", int'(ovf), 0);
    drain(20);

    // Missing column 3 valid, then a good vector.
    m_if.m_ready = 1'b1;
    vbuf[0] = mkvec(500);
    send(0, 1, 3, 1'b0);
    tick();
    chkn("mis_flag", int'(mis), 1);
    chkn("mis_level", int'(lvl), 0);
    vbuf[0] = mkvec(600);
    expq.push_back(vbuf[0]);
    send(0, 1, -1, 1'b0);
    repeat (2) tick();
    chkn("mis_next_q", expq.size(), 0);
    chkn("mis_sticky", int'(mis), 1);

    // Negative, zero and extreme lanes.
    rv = '0;
    rv[0*W +: W] = -32'sd5;
    rv[1*W +: W] = 32'd0;
    rv[2*W +: W] = 32'd7;
    rv[3*W +: W] = 32'h8000_0000;
    rv[4*W +: W] = 32'd3;
    rv[5*W +: W] = 32'hffff_ffff;
    rv[6*W +: W] = 32'd100;
    rv[7*W +: W] = 32'h7fff_ffff;
`ifdef DESKEW_RELU_EN
    re = '0;
    re[2*W +: W] = 32'd7;
    re[4*W +: W] = 32'd3;
    re[6*W +: W] = 32'd100;
    re[7*W +: W] = 32'h7fff_ffff;
`else
    re = rv;
`endif
    vbuf[0] = rv;
    expq.push_back(re);
    send(0, 1, -1, 1'b0);
    repeat (2) tick();
    chkn("relu_q", expq.size(), 0);

    // Reset in the middle of a vector.
    m_if.m_ready = 1'b0;
    vbuf[0] = mkvec(700);
    send(0, 1, -1, 1'b0);
    chkn("rst_pre_level", int'(lvl), 1);
    chkn("rst_pre_mis", int'(mis), 1);
    vbuf[1] = mkvec(800);
    drive(1, 1, -1, 0, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    tick();
    rst_n = 1'b1;
    drive(1, 1, -1, 4, N - 1, 1'b0);
    repeat (N) tick();
    chk_zero("rst_after");

    // Clear in the middle of a vector.
    vbuf[0] = mkvec(900);
    send(0, 1, -1, 1'b0);
    send(0, 1, 2, 1'b0);
    chkn("clr_pre_level", int'(lvl), 1);
    chkn("clr_pre_mis", int'(mis), 1);
    vbuf[1] = mkvec(950);
    drive(1, 1, -1, 0, 3, 1'b0);
    clear = 1'b1;
    drive(1, 1, -1, 4, 4, 1'b0);
    clear = 1'b0;
    chk_zero("clr_edge");
    drive(1, 1, -1, 5, N - 1, 1'b0);
    repeat (N) tick();
    chk_zero("clr_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
